snake_game_sequencer: RTL and testbench

Game-level controller for the snake position datapath. It runs the start/run/pause/dead state machine and generates the per-move step enable, so the snake advances one grid step per tick instead of every clock. It also detects apple capture, grows the snake length, and speeds up the tick rate as the score increases. It sits between the debounced button inputs, the snake position datapath, and the apple generator.

---
 rtl/snake_game_sequencer_if.sv | 34 +++
 rtl/snake_game_sequencer.sv | 151 +++++++++++++++
 tb/tb_snake_game_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_game_sequencer_if.sv
// Button, datapath and apple-generator signals seen by the snake game sequencer.
// master is the sequencer side; slave is the surrounding game logic.
interface snake_game_sequencer_if;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned VEL_W   = 4;
    localparam int unsigned STATE_W = 3;

    logic               start_btn;
    logic               pause_btn;
    logic [POS_W-1:0]   head_x;
    logic [POS_W-1:0]   head_y;
    logic [POS_W-1:0]   apple_x;
    logic [POS_W-1:0]   apple_y;
    logic               hit;
    logic               pos_reset;
    logic [VEL_W-1:0]   velocity;
    logic               move_tick;
    logic [LEN_W-1:0]   length;
    logic [LEN_W-1:0]   score;
    logic               apple_req;
    logic               game_over;
    logic [STATE_W-1:0] state;

    modport master (
        input  start_btn, pause_btn, head_x, head_y, apple_x, apple_y, hit,
        output pos_reset, velocity, move_tick, length, score, apple_req, game_over, state
    );

    modport slave (
        output start_btn, pause_btn, head_x, head_y, apple_x, apple_y, hit,
        input  pos_reset, velocity, move_tick, length, score, apple_req, game_over, state
    );
endinterface

// File: rtl/snake_game_sequencer.sv
// Snake game controller: start/run/pause/dead FSM, per-move step enable,
// apple capture with length/score growth and tick-rate speed-up.
module snake_game_sequencer #(
    parameter int unsigned TICK_DIV_INIT = 2500000,
    parameter int unsigned TICK_DIV_MIN  = 1000000,
    parameter int unsigned TICK_DIV_STEP = 100000,
    parameter int unsigned STEP_PX       = 10,
    parameter int unsigned LEN_INIT      = 3,
    parameter int unsigned LEN_MAX       = 99,
    parameter int unsigned HIT_RADIUS    = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    snake_game_sequencer_if.master bus
);
    localparam int unsigned CNT_W  = 22;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned DIFF_W = 11;
    localparam int unsigned VEL_W  = 4;
    localparam logic [LEN_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_CHECK = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DEAD  = 3'd4
    } state_e;

    state_e             state_q, nxt_state;
    logic [CNT_W-1:0]   tick_cnt, tick_div, nxt_cnt, nxt_div, faster_div;
    logic [LEN_W-1:0]   len_q, score_q, nxt_len, nxt_score;
    logic               start_d, pause_d, start_rise, pause_rise;
    logic [DIFF_W-1:0]  dx_diff, dy_diff, dx_mag, dy_mag;
    logic               capture, nxt_apple, nxt_move;
    logic               pos_reset_q, move_q, apple_req_q, game_over_q;
    logic [VEL_W-1:0]   velocity_q;

    assign start_rise = bus.start_btn & ~start_d;
    assign pause_rise = bus.pause_btn & ~pause_d;

    // Per-axis unsigned distance between head and apple
    assign dx_diff = {1'b0, bus.head_x} - {1'b0, bus.apple_x};
    assign dy_diff = {1'b0, bus.head_y} - {1'b0, bus.apple_y};
    assign dx_mag  = dx_diff[DIFF_W-1] ? (~dx_diff + DIFF_W'(1)) : dx_diff;
    assign dy_mag  = dy_diff[DIFF_W-1] ? (~dy_diff + DIFF_W'(1)) : dy_diff;
    assign capture = (dx_mag < DIFF_W'(HIT_RADIUS)) && (dy_mag < DIFF_W'(HIT_RADIUS));

    assign faster_div = (tick_div >= CNT_W'(TICK_DIV_MIN + TICK_DIV_STEP))
                      ? (tick_div - CNT_W'(TICK_DIV_STEP)) : CNT_W'(TICK_DIV_MIN);

    // Next-state and next-counter logic
    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = tick_cnt;
        nxt_div   = tick_div;
        nxt_len   = len_q;
        nxt_score = score_q;
        nxt_apple = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    nxt_state = ST_RUN;
                    nxt_cnt   = '0;
                    nxt_div   = CNT_W'(TICK_DIV_INIT);
                    nxt_len   = LEN_W'(LEN_INIT);
                    nxt_score = '0;
                end
            end
            ST_RUN: begin
                // A move in progress wins over a pause request
                if (tick_cnt == tick_div - CNT_W'(1)) begin
                    nxt_state = ST_CHECK;
                    nxt_cnt   = '0;
                end else if (pause_rise) begin
                    nxt_state = ST_PAUSE;
                end else begin
                    nxt_cnt = tick_cnt + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                nxt_cnt = tick_cnt + CNT_W'(1);
                if (bus.hit) begin
                    nxt_state = ST_DEAD;
                end else begin
                    nxt_state = ST_RUN;
                    if (capture) begin
                        nxt_apple = 1'b1;
                        nxt_score = (score_q != SCORE_MAX) ? score_q + LEN_W'(1) : score_q;
                        nxt_len   = (len_q < LEN_W'(LEN_MAX)) ? len_q + LEN_W'(1) : len_q;
                        nxt_div   = faster_div;
                    end
                end
            end
            ST_PAUSE: begin
                if (start_rise) begin
                    nxt_state = ST_IDLE;
                end else if (pause_rise) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (start_rise) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        // Registered move outputs line up with the cycle whose count reaches tick_div-1
        nxt_move = (nxt_state == ST_RUN) && (nxt_cnt == nxt_div - CNT_W'(1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tick_cnt    <= '0;
            tick_div    <= CNT_W'(TICK_DIV_INIT);
            len_q       <= LEN_W'(LEN_INIT);
            score_q     <= '0;
            start_d     <= 1'b1;
            pause_d     <= 1'b1;
            pos_reset_q <= 1'b1;
            move_q      <= 1'b0;
            velocity_q  <= '0;
            apple_req_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            tick_cnt    <= nxt_cnt;
            tick_div    <= nxt_div;
            len_q       <= nxt_len;
            score_q     <= nxt_score;
            start_d     <= bus.start_btn;
            pause_d     <= bus.pause_btn;
            pos_reset_q <= (nxt_state == ST_IDLE);
            move_q      <= nxt_move;
            velocity_q  <= nxt_move ? VEL_W'(STEP_PX) : '0;
            apple_req_q <= nxt_apple;
            game_over_q <= (nxt_state == ST_DEAD);
        end
    end

    assign bus.pos_reset = pos_reset_q;
    assign bus.velocity  = velocity_q;
    assign bus.move_tick = move_q;
    assign bus.length    = len_q;
    assign bus.score     = score_q;
    assign bus.apple_req = apple_req_q;
    assign bus.game_over = game_over_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_snake_game_sequencer.sv
// Bench for snake_game_sequencer: countdown-style game model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_snake_game_sequencer;
    localparam int DIV_INIT = 8;
    localparam int DIV_MIN  = 4;
    localparam int DIV_STEP = 2;
    localparam int STEP     = 10;
    localparam int LEN0     = 3;
    localparam int LMAX     = 5;
    localparam int RAD      = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    snake_game_sequencer_if bus();

    snake_game_sequencer #(
        .TICK_DIV_INIT(DIV_INIT), .TICK_DIV_MIN(DIV_MIN), .TICK_DIV_STEP(DIV_STEP),
        .STEP_PX(STEP), .LEN_INIT(LEN0), .LEN_MAX(LMAX), .HIT_RADIUS(RAD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: mode 0 idle, 1 run, 2 check, 3 pause, 4 dead.
    // m_left = clocks left in the current move period, counting the current one.
    int m_mode, m_left, m_period, m_len, m_score;
    bit m_apple, m_ps, m_pp;
    logic m_sr, m_pr;
    assign m_sr = bus.start_btn & ~m_ps;
    assign m_pr = bus.pause_btn & ~m_pp;

    function automatic bit near(input int hx, input int hy, input int ax, input int ay);
        int ddx, ddy;
        ddx = (hx > ax) ? hx - ax : ax - hx;
        ddy = (hy > ay) ? hy - ay : ay - hy;
        return (ddx < RAD) && (ddy < RAD);
    endfunction

    function automatic int faster(input int p);
        return (p - DIV_STEP > DIV_MIN) ? p - DIV_STEP : DIV_MIN;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode <= 0; m_left <= 0; m_period <= DIV_INIT;
            m_len <= LEN0; m_score <= 0; m_apple <= 1'b0; m_ps <= 1'b1; m_pp <= 1'b1;
        end else begin
            m_ps    <= bus.start_btn;
            m_pp    <= bus.pause_btn;
            m_apple <= 1'b0;
            case (m_mode)
                0: if (m_sr) begin
                       m_mode <= 1; m_period <= DIV_INIT; m_left <= DIV_INIT;
                       m_len <= LEN0; m_score <= 0;
                   end
                1: if (m_left == 1) m_mode <= 2;
                   else if (m_pr) m_mode <= 3;
                   else m_left <= m_left - 1;
                2: if (bus.hit) m_mode <= 4;
                   else begin
                       m_mode <= 1;
                       if (near(int'(bus.head_x), int'(bus.head_y), int'(bus.apple_x), int'(bus.apple_y))) begin
                           m_apple  <= 1'b1;
                           m_score  <= (m_score < 1023) ? m_score + 1 : m_score;
                           m_len    <= (m_len < LMAX) ? m_len + 1 : LMAX;
                           m_period <= faster(m_period);
                           m_left   <= faster(m_period) - 1;
                       end else begin
                           m_left <= m_period - 1;
                       end
                   end
                3: if (m_sr) m_mode <= 0;
                   else if (m_pr) m_mode <= 1;
                4: if (m_sr) m_mode <= 0;
                default: m_mode <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_en) begin
            check("state",     int'(bus.state),     m_mode);
            check("pos_reset", int'(bus.pos_reset), int'(m_mode == 0));
            check("move_tick", int'(bus.move_tick), int'(m_mode == 1 && m_left == 1));
            check("velocity",  int'(bus.velocity),  (m_mode == 1 && m_left == 1) ? STEP : 0);
            check("game_over", int'(bus.game_over), int'(m_mode == 4));
            check("apple_req", int'(bus.apple_req), int'(m_apple));
            check("length",    int'(bus.length),    m_len);
            check("score",     int'(bus.score),     m_score);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_move(input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            cyc(1);
            n++;
            seen = bus.move_tick;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL move_timeout: no move_tick within %0d clocks", limit);
        end
    endtask

    // Called inside a move cycle: present geometry for the following CHECK cycle
    task automatic do_check(input int ax, input int ay, input bit h);
        bus.apple_x = 10'(ax);
        bus.apple_y = 10'(ay);
        bus.hit     = h;
        cyc(2);
        bus.apple_x = 10'd500;
        bus.apple_y = 10'd400;
        bus.hit     = 1'b0;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        cyc(1);
        bus.start_btn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int quiet;
        bus.start_btn = 1'b1;
        bus.pause_btn = 1'b0;
        bus.head_x = 10'd100; bus.head_y = 10'd100;
        bus.apple_x = 10'd500; bus.apple_y = 10'd400;
        bus.hit = 1'b0;

        // 1: start held across reset release does not start a game
        cyc(3);
        cmp_en = 1'b1;
        reset = 1'b1;
        cyc(3);
        check("t1_idle_state", int'(bus.state), 0);
        check("t1_idle_pos_reset", int'(bus.pos_reset), 1);
        bus.start_btn = 1'b0;
        cyc(1);
        press_start();
        check("t1_run_state", int'(bus.state), 1);
        check("t1_run_pos_reset", int'(bus.pos_reset), 0);
        wait_move(20, n);
        check("t1_first_move", n + 1, 8);
        check("t1_velocity", int'(bus.velocity), 10);
        wait_move(20, n);
        check("t1_period", n, 8);

        // 2: captures grow length/score and shorten the period, both saturating
        do_check(105, 95, 1'b0);
        check("t2_apple_req", int'(bus.apple_req), 1);
        check("t2_score1", int'(bus.score), 1);
        check("t2_len4", int'(bus.length), 4);
        wait_move(20, n);
        check("t2_period6", n + 2, 6);
        do_check(95, 105, 1'b0);
        check("t2_len5", int'(bus.length), 5);
        wait_move(20, n);
        check("t2_period4", n + 2, 4);
        for (int i = 0; i < 2; i++) begin
            do_check(105, 95, 1'b0);
            wait_move(20, n);
        end
        check("t2_len_sat", int'(bus.length), 5);
        check("t2_score4", int'(bus.score), 4);
        check("t2_period_sat", n + 2, 4);

        // 3: radius boundary is exclusive; hit wins over a capture
        do_check(110, 100, 1'b0);
        check("t3_no_capture", int'(bus.apple_req), 0);
        check("t3_score_kept", int'(bus.score), 4);
        wait_move(20, n);
        do_check(105, 95, 1'b1);
        check("t3_dead", int'(bus.state), 4);
        check("t3_game_over", int'(bus.game_over), 1);
        check("t3_dead_score", int'(bus.score), 4);
        check("t3_dead_len", int'(bus.length), 5);
        cyc(3);

        // 5: dead -> idle -> fresh game
        press_start();
        check("t5_idle", int'(bus.state), 0);
        check("t5_pos_reset", int'(bus.pos_reset), 1);
        cyc(2);
        press_start();
        check("t5_len_init", int'(bus.length), 3);
        check("t5_score_init", int'(bus.score), 0);
        wait_move(20, n);
        check("t5_period8", n + 1, 8);

        // 4: pause at tick count 3 for 50 clocks, then resume
        cyc(4);
        bus.pause_btn = 1'b1;
        cyc(1);
        bus.pause_btn = 1'b0;
        check("t4_paused", int'(bus.state), 3);
        quiet = 0;
        repeat (49) begin
            cyc(1);
            if (bus.velocity != 4'd0 || bus.move_tick) quiet++;
        end
        check("t4_pause_velocity", quiet, 0);
        bus.pause_btn = 1'b1;
        wait_move(20, n);
        bus.pause_btn = 1'b0;
        check("t4_resume_5", n, 5);
        do_check(105, 95, 1'b0);
        check("t4_score1", int'(bus.score), 1);
        wait_move(20, n);
        check("t4_period6", n + 2, 6);

        // 6: reset during a CHECK with a capture pending
        bus.apple_x = 10'd105;
        bus.apple_y = 10'd95;
        cyc(1);
        reset = 1'b0;
        #1;
        check("t6_state", int'(bus.state), 0);
        check("t6_pos_reset", int'(bus.pos_reset), 1);
        check("t6_apple_req", int'(bus.apple_req), 0);
        check("t6_len", int'(bus.length), 3);
        check("t6_score", int'(bus.score), 0);
        cyc(3);
        check("t6_apple_req_hold", int'(bus.apple_req), 0);
        bus.apple_x = 10'd500;
        bus.apple_y = 10'd400;
        reset = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
